// File: rtl/sfp_ctrl_pkg.sv
// Shared types and helpers for the SFP cage controller.
package sfp_ctrl_pkg;

    // Channel state encoding as reported on sts_state.
    typedef enum logic [2:0] {
        ST_ABSENT    = 3'd0,
        ST_INSERT    = 3'd1,
        ST_OFF       = 3'd2,
        ST_POWER     = 3'd3,
        ST_READY     = 3'd4,
        ST_FAULT_RST = 3'd5,
        ST_FAULT     = 3'd6
    } sfp_state_e;

    // Width of the tx_fault retry counter (MAX_RETRY is at most 15).
    localparam int RETRY_W = 4;

    // Counter width large enough to hold the longest of the three intervals.
    function automatic int cnt_width(input int deb, input int pwr, input int rst_t);
        int m;
        m = deb;
        if (pwr > m) m = pwr;
        if (rst_t > m) m = rst_t;
        return $clog2(m + 1);
    endfunction

    // Module power is applied in these states.
    function automatic logic is_powered(input sfp_state_e s);
        return (s == ST_POWER) || (s == ST_READY) || (s == ST_FAULT_RST) || (s == ST_FAULT);
    endfunction

    // Debounced los is only meaningful once the module has finished init.
    function automatic logic los_valid(input sfp_state_e s);
        return (s == ST_READY) || (s == ST_FAULT_RST) || (s == ST_FAULT);
    endfunction

    // Saturating increment of the retry count.
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] r);
        return (r == '1) ? r : r + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/sfp_ctrl_chan.sv
// One SFP cage: pin synchronisers, detect/los debounce, power/Tx sequencing
// FSM with bounded fault recovery, and registered host status.
module sfp_ctrl_chan
    import sfp_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 1000,
    parameter int T_PWR      = 50000,
    parameter int T_RST      = 1000,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cfg_admin_en,
    input  logic       i_cfg_tx_en,
    input  logic [1:0] i_cfg_rate_sel,
    input  logic       i_cfg_fault_clr,
    input  logic       i_sfp_detect_n,
    input  logic       i_sfp_los,
    input  logic       i_sfp_tx_fault,
    output logic       o_sfp_ena_n,
    output logic       o_sfp_tx_disable,
    output logic [1:0] o_sfp_rate_sel,
    output logic       o_sts_present,
    output logic       o_sts_los,
    output logic       o_sts_fault,
    output logic [2:0] o_sts_state,
    output logic       o_sts_evt
);

    localparam int CNT_W = cnt_width(DEB_CYCLES, T_PWR, T_RST);

    // Terminal counts: an interval of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(T_RST - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    // Synchroniser stages
    logic r_det_meta, r_det_s;
    logic r_los_meta, r_los_s;
    logic r_flt_meta, r_flt_s;

    // FSM state, shared interval counter, retry count
    sfp_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;

    // Independent los debounce
    logic               r_los_deb;
    logic [CNT_W-1:0]   r_los_cnt;

    // Registered outputs
    logic       r_ena_n, r_tx_dis, r_present, r_los, r_fault, r_evt;
    logic [1:0] r_rate;

    // Next-state values
    sfp_state_e         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [RETRY_W-1:0] w_retry_base;
    logic               w_los_deb_nxt;
    logic [CNT_W-1:0]   w_los_cnt_nxt;
    logic       w_ena_n_nxt, w_tx_dis_nxt, w_present_nxt, w_los_nxt, w_fault_nxt, w_evt_nxt;
    logic [1:0] w_rate_nxt;

    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_retry_base = i_cfg_fault_clr ? '0 : r_retry;

    // Two-flop synchronisers on the asynchronous cage status pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_det_meta <= 1'b0;
            r_det_s    <= 1'b0;
            r_los_meta <= 1'b0;
            r_los_s    <= 1'b0;
            r_flt_meta <= 1'b0;
            r_flt_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage samples the pre-edge value of the one before it.
            r_det_meta <= ~i_sfp_detect_n;
            r_det_s    <= r_det_meta;
            r_los_meta <= i_sfp_los;
            r_los_s    <= r_los_meta;
            r_flt_meta <= i_sfp_tx_fault;
            r_flt_s    <= r_flt_meta;
        end
    end

    // Los debounce: adopt a new los level only after DEB_CYCLES consecutive samples.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned.
        w_los_deb_nxt = r_los_deb;
        w_los_cnt_nxt = '0;
        if (r_los_s != r_los_deb) begin
            if (r_los_cnt == DEB_LAST) begin
                w_los_deb_nxt = r_los_s;
            end else begin
                w_los_cnt_nxt = r_los_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic; removal beats fault clear beats admin disable beats tx_fault beats timers.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = w_retry_base;
        if (!r_det_s && (r_state != ST_ABSENT)) begin
            w_state_nxt = ST_ABSENT;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else if ((r_state == ST_FAULT) && i_cfg_fault_clr) begin
            w_state_nxt = ST_POWER;
            w_cnt_nxt   = '0;
        end else if (!i_cfg_admin_en && is_powered(r_state)) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_ABSENT: begin
                    w_retry_nxt = '0;
                    if (r_det_s) begin
                        w_state_nxt = ST_INSERT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_INSERT: begin
                    if (r_cnt == DEB_LAST) begin
                        w_state_nxt = i_cfg_admin_en ? ST_POWER : ST_OFF;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_OFF: begin
                    w_retry_nxt = '0;
                    if (i_cfg_admin_en) begin
                        w_state_nxt = ST_POWER;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_POWER: begin
                    // tx_fault is ignored while the module initialises.
                    if (r_cnt == PWR_LAST) begin
                        w_state_nxt = ST_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_READY: begin
                    if (r_flt_s) begin
                        w_state_nxt = ST_FAULT_RST;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = retry_inc(w_retry_base);
                    end
                end
                ST_FAULT_RST: begin
                    if (r_cnt == RST_LAST) begin
                        w_cnt_nxt = '0;
                        if (!r_flt_s) begin
                            w_state_nxt = ST_READY;
                        end else if (w_retry_base < RETRY_MAX) begin
                            w_retry_nxt = retry_inc(w_retry_base);
                        end else begin
                            w_state_nxt = ST_FAULT;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_ABSENT;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            endcase
        end
    end

    // Output values decoded from the next state so they load with the state register.
    always_comb begin
        w_ena_n_nxt   = ~is_powered(w_state_nxt);
        w_tx_dis_nxt  = ~((w_state_nxt == ST_READY) && i_cfg_tx_en);
        w_rate_nxt    = ((w_state_nxt == ST_POWER) || (w_state_nxt == ST_READY)) ? i_cfg_rate_sel : 2'b00;
        w_present_nxt = (w_state_nxt != ST_ABSENT) && (w_state_nxt != ST_INSERT);
        w_los_nxt     = los_valid(w_state_nxt) && w_los_deb_nxt;
        w_fault_nxt   = (w_state_nxt == ST_FAULT);
        w_evt_nxt     = (w_present_nxt != r_present) || (w_los_nxt != r_los) || (w_fault_nxt != r_fault);
    end

    // State, counters and registered outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ABSENT;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_los_deb <= 1'b0;
            r_los_cnt <= '0;
            r_ena_n   <= 1'b1;
            r_tx_dis  <= 1'b1;
            r_rate    <= 2'b00;
            r_present <= 1'b0;
            r_los     <= 1'b0;
            r_fault   <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            r_los_deb <= w_los_deb_nxt;
            r_los_cnt <= w_los_cnt_nxt;
            r_ena_n   <= w_ena_n_nxt;
            r_tx_dis  <= w_tx_dis_nxt;
            r_rate    <= w_rate_nxt;
            r_present <= w_present_nxt;
            r_los     <= w_los_nxt;
            r_fault   <= w_fault_nxt;
            r_evt     <= w_evt_nxt;
        end
    end

    assign o_sfp_ena_n      = r_ena_n;
    assign o_sfp_tx_disable = r_tx_dis;
    assign o_sfp_rate_sel   = r_rate;
    assign o_sts_present    = r_present;
    assign o_sts_los        = r_los;
    assign o_sts_fault      = r_fault;
    assign o_sts_state      = r_state;
    assign o_sts_evt        = r_evt;

endmodule

// File: rtl/sfp_ctrl_seq.sv
// SFP cage manager: NB_SFP independent channels between host registers and cage pins.
// The rate-select buses are [0]/[1] arrays indexed by cage, like the pin bus.
module sfp_ctrl_seq
    import sfp_ctrl_pkg::*;
#(
    parameter int NB_SFP     = 4,
    parameter int DEB_CYCLES = 1000,
    parameter int T_PWR      = 50000,
    parameter int T_RST      = 1000,
    parameter int MAX_RETRY  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NB_SFP-1:0]      cfg_admin_en,
    input  logic [NB_SFP-1:0]      cfg_tx_en,
    input  logic [1:0][NB_SFP-1:0] cfg_rate_sel,
    input  logic [NB_SFP-1:0]      cfg_fault_clr,
    input  logic [NB_SFP-1:0]      sfp_detect_n,
    input  logic [NB_SFP-1:0]      sfp_los,
    input  logic [NB_SFP-1:0]      sfp_tx_fault,
    output logic [NB_SFP-1:0]      sfp_ena_n,
    output logic [NB_SFP-1:0]      sfp_tx_disable,
    output logic [1:0][NB_SFP-1:0] sfp_rate_sel,
    output logic [NB_SFP-1:0]      sts_present,
    output logic [NB_SFP-1:0]      sts_los,
    output logic [NB_SFP-1:0]      sts_fault,
    output logic [NB_SFP-1:0][2:0] sts_state,
    output logic [NB_SFP-1:0]      sts_evt
);

    for (genvar g = 0; g < NB_SFP; g++) begin : g_chan
        logic [1:0] w_rate;

        sfp_ctrl_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .T_PWR      (T_PWR),
            .T_RST      (T_RST),
            .MAX_RETRY  (MAX_RETRY)
        ) u_chan (
            .clk              (clk),
            .rst              (rst),
            .i_cfg_admin_en   (cfg_admin_en[g]),
            .i_cfg_tx_en      (cfg_tx_en[g]),
            .i_cfg_rate_sel   ({cfg_rate_sel[1][g], cfg_rate_sel[0][g]}),
            .i_cfg_fault_clr  (cfg_fault_clr[g]),
            .i_sfp_detect_n   (sfp_detect_n[g]),
            .i_sfp_los        (sfp_los[g]),
            .i_sfp_tx_fault   (sfp_tx_fault[g]),
            .o_sfp_ena_n      (sfp_ena_n[g]),
            .o_sfp_tx_disable (sfp_tx_disable[g]),
            .o_sfp_rate_sel   (w_rate),
            .o_sts_present    (sts_present[g]),
            .o_sts_los        (sts_los[g]),
            .o_sts_fault      (sts_fault[g]),
            .o_sts_state      (sts_state[g]),
            .o_sts_evt        (sts_evt[g])
        );

        assign sfp_rate_sel[0][g] = w_rate[0];
        assign sfp_rate_sel[1][g] = w_rate[1];
    end

endmodule

// File: tb/tb_sfp_ctrl_seq.sv
// Directed bench for sfp_ctrl_seq with a time-stamped expectation scoreboard.
module tb_sfp_ctrl_seq;
    import sfp_ctrl_pkg::*;

    localparam int NB   = 2;
    localparam int DEB  = 4;
    localparam int TPWR = 8;
    localparam int TRST = 4;
    localparam int MAXR = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NB-1:0]       cfg_admin_en, cfg_tx_en, cfg_fault_clr;
    logic [1:0][NB-1:0]  cfg_rate_sel;
    logic [NB-1:0]       sfp_detect_n, sfp_los, sfp_tx_fault;
    logic [NB-1:0]       sfp_ena_n, sfp_tx_disable;
    logic [1:0][NB-1:0]  sfp_rate_sel;
    logic [NB-1:0]       sts_present, sts_los, sts_fault, sts_evt;
    logic [NB-1:0][2:0]  sts_state;

    always #5 clk = ~clk;

    sfp_ctrl_seq #(
        .NB_SFP(NB), .DEB_CYCLES(DEB), .T_PWR(TPWR), .T_RST(TRST), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_admin_en(cfg_admin_en), .cfg_tx_en(cfg_tx_en),
        .cfg_rate_sel(cfg_rate_sel), .cfg_fault_clr(cfg_fault_clr),
        .sfp_detect_n(sfp_detect_n), .sfp_los(sfp_los), .sfp_tx_fault(sfp_tx_fault),
        .sfp_ena_n(sfp_ena_n), .sfp_tx_disable(sfp_tx_disable), .sfp_rate_sel(sfp_rate_sel),
        .sts_present(sts_present), .sts_los(sts_los), .sts_fault(sts_fault),
        .sts_state(sts_state), .sts_evt(sts_evt)
    );

    typedef enum int {
        SIG_STATE0, SIG_STATE1, SIG_ENA, SIG_TXDIS, SIG_RATE,
        SIG_PRES, SIG_LOS, SIG_FAULT, SIG_EVT
    } sig_e;

    typedef struct {
        int          at;
        sig_e        sig;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   took;

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SIG_STATE0: return 32'(sts_state[0]);
            SIG_STATE1: return 32'(sts_state[1]);
            SIG_ENA:    return 32'(sfp_ena_n);
            SIG_TXDIS:  return 32'(sfp_tx_disable);
            SIG_RATE:   return 32'({sfp_rate_sel[1], sfp_rate_sel[0]});
            SIG_PRES:   return 32'(sts_present);
            SIG_LOS:    return 32'(sts_los);
            SIG_FAULT:  return 32'(sts_fault);
            SIG_EVT:    return 32'(sts_evt);
            default:    return 32'hdead_beef;
        endcase
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Compare and retire every expectation that has come due.
    task automatic drain();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                compare(sb[i].tag, observe(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            drain();
        end
    endtask

    task automatic expect_at(input int dt, input sig_e s, input logic [31:0] e, input string tag);
        sb.push_back('{cyc + dt, s, e, tag});
    endtask

    task automatic expect_now(input sig_e s, input logic [31:0] e, input string tag);
        expect_at(0, s, e, tag);
        drain();
    endtask

    // Bounded wait for sts_fault on a channel; returns edges taken or -1.
    task automatic wait_fault(input int ch, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            step(1);
            if (sts_fault[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        // Reset with every pin active
        rst             = 1'b1;
        cfg_admin_en    = '0;
        cfg_tx_en       = '0;
        cfg_fault_clr   = '0;
        cfg_rate_sel[0] = 2'b11;
        cfg_rate_sel[1] = 2'b01;
        sfp_detect_n    = '0;
        sfp_los         = '1;
        sfp_tx_fault    = '1;
        step(3);
        expect_now(SIG_ENA,    2'b11, "rst_ena");
        expect_now(SIG_TXDIS,  2'b11, "rst_txdis");
        expect_now(SIG_RATE,   4'h0,  "rst_rate");
        expect_now(SIG_PRES,   2'b00, "rst_pres");
        expect_now(SIG_LOS,    2'b00, "rst_los");
        expect_now(SIG_FAULT,  2'b00, "rst_fault");
        expect_now(SIG_EVT,    2'b00, "rst_evt");
        expect_now(SIG_STATE0, ST_ABSENT, "rst_state0");
        expect_now(SIG_STATE1, ST_ABSENT, "rst_state1");

        rst          = 1'b0;
        sfp_detect_n = '1;
        sfp_los      = '0;
        sfp_tx_fault = '0;
        cfg_admin_en = '1;
        cfg_tx_en    = '1;
        step(4);
        expect_now(SIG_STATE0, ST_ABSENT, "idle_state0");

        // Insertion of cage 0
        sfp_detect_n[0] = 1'b0;
        expect_at(2,  SIG_STATE0, ST_ABSENT, "ins_sync_lag");
        expect_at(3,  SIG_STATE0, ST_INSERT, "ins_insert");
        expect_at(3,  SIG_ENA,    2'b11,     "ins_ena_off");
        expect_at(6,  SIG_STATE0, ST_INSERT, "ins_deb_hold");
        expect_at(6,  SIG_PRES,   2'b00,     "ins_pres_early");
        expect_at(7,  SIG_STATE0, ST_POWER,  "ins_power");
        expect_at(7,  SIG_ENA,    2'b10,     "ins_ena_on");
        expect_at(7,  SIG_PRES,   2'b01,     "ins_pres");
        expect_at(7,  SIG_EVT,    2'b01,     "ins_evt");
        expect_at(7,  SIG_RATE,   4'h5,      "ins_rate");
        expect_at(7,  SIG_TXDIS,  2'b11,     "ins_txdis_pwr");
        expect_at(8,  SIG_EVT,    2'b00,     "ins_evt_pulse");
        expect_at(14, SIG_STATE0, ST_POWER,  "ins_pwr_hold");
        expect_at(14, SIG_TXDIS,  2'b11,     "ins_txdis_hold");
        expect_at(15, SIG_STATE0, ST_READY,  "ins_ready");
        expect_at(15, SIG_TXDIS,  2'b10,     "ins_txdis_on");
        expect_at(15, SIG_STATE1, ST_ABSENT, "ins_ch1_idle");
        step(16);

        // Short bounce on cage 1
        sfp_detect_n[1] = 1'b0;
        expect_at(3, SIG_STATE1, ST_INSERT, "bnc_insert");
        expect_at(4, SIG_EVT,    2'b00,     "bnc_evt4");
        expect_at(5, SIG_STATE1, ST_INSERT, "bnc_hold");
        expect_at(6, SIG_STATE1, ST_ABSENT, "bnc_absent");
        expect_at(6, SIG_ENA,    2'b10,     "bnc_ena");
        expect_at(6, SIG_PRES,   2'b01,     "bnc_pres");
        expect_at(6, SIG_EVT,    2'b00,     "bnc_evt6");
        step(3);
        sfp_detect_n[1] = 1'b1;
        step(4);

        // tx_fault retry exhaustion on cage 0
        sfp_tx_fault[0] = 1'b1;
        expect_at(2,  SIG_STATE0, ST_READY,     "flt_sync_lag");
        expect_at(3,  SIG_STATE0, ST_FAULT_RST, "flt_rst1");
        expect_at(3,  SIG_TXDIS,  2'b11,        "flt_txdis");
        expect_at(3,  SIG_ENA,    2'b10,        "flt_ena");
        expect_at(3,  SIG_EVT,    2'b00,        "flt_evt_none");
        expect_at(7,  SIG_STATE0, ST_FAULT_RST, "flt_rst2");
        expect_at(10, SIG_STATE0, ST_FAULT_RST, "flt_rst2_end");
        expect_at(10, SIG_FAULT,  2'b00,        "flt_not_yet");
        wait_fault(0, 30, took);
        compare("flt_latency", took, 11);
        expect_now(SIG_STATE0, ST_FAULT, "flt_state");
        expect_now(SIG_FAULT,  2'b01,    "flt_sts");
        expect_now(SIG_ENA,    2'b10,    "flt_ena_on");
        expect_now(SIG_TXDIS,  2'b11,    "flt_txdis_off");
        expect_now(SIG_EVT,    2'b01,    "flt_evt");
        sfp_tx_fault[0] = 1'b0;
        step(5);
        expect_now(SIG_STATE0, ST_FAULT, "flt_latched");

        cfg_fault_clr[0] = 1'b1;
        expect_at(1, SIG_STATE0, ST_POWER, "clr_power");
        expect_at(1, SIG_FAULT,  2'b00,    "clr_fault");
        expect_at(1, SIG_EVT,    2'b01,    "clr_evt");
        expect_at(1, SIG_ENA,    2'b10,    "clr_ena");
        expect_at(8, SIG_STATE0, ST_POWER, "clr_pwr_hold");
        expect_at(9, SIG_STATE0, ST_READY, "clr_ready");
        expect_at(9, SIG_TXDIS,  2'b10,    "clr_txdis");
        step(1);
        cfg_fault_clr[0] = 1'b0;
        step(8);

        // Cage 1 removed during POWER
        sfp_detect_n[1] = 1'b0;
        expect_at(7,  SIG_STATE1, ST_POWER,  "rmv_power");
        expect_at(7,  SIG_ENA,    2'b00,     "rmv_ena_both");
        expect_at(7,  SIG_PRES,   2'b11,     "rmv_pres_both");
        expect_at(7,  SIG_EVT,    2'b10,     "rmv_evt_ins");
        expect_at(7,  SIG_RATE,   4'h7,      "rmv_rate_both");
        expect_at(12, SIG_STATE1, ST_POWER,  "rmv_sync_lag");
        expect_at(13, SIG_STATE1, ST_ABSENT, "rmv_absent");
        expect_at(13, SIG_ENA,    2'b10,     "rmv_ena");
        expect_at(13, SIG_RATE,   4'h5,      "rmv_rate");
        expect_at(13, SIG_PRES,   2'b01,     "rmv_pres");
        expect_at(13, SIG_EVT,    2'b10,     "rmv_evt");
        expect_at(14, SIG_EVT,    2'b00,     "rmv_evt_pulse");
        step(10);
        sfp_detect_n[1] = 1'b1;
        step(4);

        // Removal, fault and admin disable reaching cage 0 on the same edge
        sfp_tx_fault[0] = 1'b1;
        sfp_detect_n[0] = 1'b1;
        expect_at(2, SIG_STATE0, ST_READY,  "sim_ready");
        expect_at(3, SIG_STATE0, ST_ABSENT, "sim_absent");
        expect_at(3, SIG_FAULT,  2'b00,     "sim_fault");
        expect_at(3, SIG_PRES,   2'b00,     "sim_pres");
        expect_at(3, SIG_ENA,    2'b11,     "sim_ena");
        expect_at(3, SIG_TXDIS,  2'b11,     "sim_txdis");
        expect_at(3, SIG_EVT,    2'b01,     "sim_evt");
        step(2);
        cfg_admin_en[0] = 1'b0;
        step(1);
        sfp_tx_fault[0] = 1'b0;
        step(2);

        // Re-insert with admin disabled, then enable
        sfp_detect_n[0] = 1'b0;
        expect_at(7, SIG_STATE0, ST_OFF, "off_state");
        expect_at(7, SIG_PRES,   2'b01,  "off_pres");
        expect_at(7, SIG_EVT,    2'b01,  "off_evt");
        expect_at(7, SIG_ENA,    2'b11,  "off_ena");
        expect_at(9, SIG_STATE0, ST_OFF, "off_hold");
        step(9);
        cfg_admin_en[0] = 1'b1;
        expect_at(1, SIG_STATE0, ST_POWER, "on_power");
        expect_at(1, SIG_ENA,    2'b10,    "on_ena");
        expect_at(1, SIG_RATE,   4'h5,     "on_rate");
        expect_at(9, SIG_STATE0, ST_READY, "on_ready");
        step(10);

        // los debounce in READY
        sfp_los[0] = 1'b1;
        expect_at(5, SIG_LOS,    2'b00,    "los_early");
        expect_at(6, SIG_LOS,    2'b01,    "los_set");
        expect_at(6, SIG_EVT,    2'b01,    "los_evt");
        expect_at(6, SIG_STATE0, ST_READY, "los_state");
        step(7);

        // Retry count cleared by the earlier removal: full two-period recovery again
        sfp_tx_fault[0] = 1'b1;
        wait_fault(0, 30, took);
        compare("flt2_latency", took, 11);
        expect_now(SIG_LOS,    2'b01,    "flt2_los_valid");
        expect_now(SIG_STATE0, ST_FAULT, "flt2_state");

        // Reset mid-operation
        rst = 1'b1;
        step(1);
        expect_now(SIG_ENA,    2'b11,     "mrst_ena");
        expect_now(SIG_TXDIS,  2'b11,     "mrst_txdis");
        expect_now(SIG_RATE,   4'h0,      "mrst_rate");
        expect_now(SIG_LOS,    2'b00,     "mrst_los");
        expect_now(SIG_FAULT,  2'b00,     "mrst_fault");
        expect_now(SIG_PRES,   2'b00,     "mrst_pres");
        expect_now(SIG_EVT,    2'b00,     "mrst_evt");
        expect_now(SIG_STATE0, ST_ABSENT, "mrst_state0");
        rst          = 1'b0;
        sfp_tx_fault = '0;
        sfp_los      = '0;
        step(2);

        compare("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
